ads131_spi_responder: RTL and testbench

//  Synthesizable SPI slave emulating the ADS131A0x command/response interface (CPOL=0, CPHA=1, 32-bit frames, MSB first).

---
 rtl/ads131_spi_responder.sv | 232 +++++++++++++++++++++++
 tb/tb_ads131_spi_responder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ads131_spi_responder.sv
// SPI slave (CPOL=0, CPHA=1) emulating the ADS131A0x command/response port:
// oversampled SPI front end, frame FSM, command decoder, 32x8 register file and DRDY timer.
module ads131_spi_responder #(
  parameter int          FRAME_BITS  = 32,
  parameter logic [15:0] READY_WORD  = 16'hFF04,
  parameter int          DRDY_PERIOD = 4000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        system_clock,
  input  logic        reset,
  input  logic        spi_sclk,
  input  logic        spi_cs,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_drdy,
  output logic [7:0]  frame_count,
  output logic [15:0] last_command,
  output logic        unlocked,
  output logic        awake
);

  localparam int                    CNT_W       = $clog2(FRAME_BITS + 1);
  localparam int                    DRDY_W      = $clog2(DRDY_PERIOD + 1);
  localparam logic [CNT_W-1:0]      FULL_CNT    = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0]      CMD_BITS    = CNT_W'(16);
  localparam logic [DRDY_W-1:0]     DRDY_LAST   = DRDY_W'(DRDY_PERIOD - 1);
  localparam logic [FRAME_BITS-1:0] READY_FRAME = FRAME_BITS'({READY_WORD, 16'h0}) << (FRAME_BITS - 32);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DECODE} state_t;
  typedef enum logic [2:0] {OP_NULL, OP_UNLOCK, OP_LOCK, OP_WAKE, OP_STBY, OP_RST, OP_WREG, OP_RREG} op_t;

  logic [SYNC_STAGES-1:0] r_sclk_sync, r_cs_sync, r_mosi_sync;
  logic                   r_sclk_d, r_cs_d;
  logic                   w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall, w_mosi;

  state_t                 r_state, w_state_nxt;
  logic                   w_load, w_decode;
  logic                   r_cs_fall_held;
  logic [CNT_W-1:0]       r_bit_cnt, w_bit_cnt_nxt;
  logic [FRAME_BITS-1:0]  r_tx_shift, r_pending, w_resp_frame;
  logic [15:0]            r_rx_cmd;
  logic [7:0]             r_regfile [32];

  op_t                    w_op;
  logic [31:0]            w_resp32, w_null32;
  logic [4:0]             w_addr;

  logic [15:0]            r_sample_cnt;
  logic [DRDY_W-1:0]      r_drdy_cnt;
  logic                   r_drdy_repulse;

  // Synchronizer stage: edges come from the last two synchronized samples
  always_ff @(posedge system_clock) begin
    if (reset) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_sclk_d    <= 1'b0;
      r_cs_d      <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      r_sclk_d    <= r_sclk_sync[SYNC_STAGES-1];
      r_cs_d      <= r_cs_sync[SYNC_STAGES-1];
    end
  end

  assign w_sclk_rise = r_sclk_sync[SYNC_STAGES-1] & ~r_sclk_d;
  assign w_sclk_fall = ~r_sclk_sync[SYNC_STAGES-1] & r_sclk_d;
  assign w_cs_rise   = r_cs_sync[SYNC_STAGES-1] & ~r_cs_d;
  assign w_cs_fall   = ~r_cs_sync[SYNC_STAGES-1] & r_cs_d;
  assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];

  // Bit count is advanced before the cs-rise test so a same-cycle last fall still completes the frame
  always_comb begin
    w_state_nxt   = r_state;
    w_load        = 1'b0;
    w_decode      = 1'b0;
    w_bit_cnt_nxt = r_bit_cnt;
    if (w_sclk_fall && (r_bit_cnt != FULL_CNT)) w_bit_cnt_nxt = r_bit_cnt + 1'b1;
    case (r_state)
      S_IDLE: begin
        if (w_cs_fall || r_cs_fall_held) begin
          w_state_nxt = S_SHIFT;
          w_load      = 1'b1;
        end
      end
      S_SHIFT: begin
        if (w_cs_rise) w_state_nxt = (w_bit_cnt_nxt == FULL_CNT) ? S_DECODE : S_IDLE;
      end
      S_DECODE: begin
        w_state_nxt = S_IDLE;
        w_decode    = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge system_clock) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_cs_fall_held <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_DECODE && w_cs_fall) r_cs_fall_held <= 1'b1;
      else if (w_load)                      r_cs_fall_held <= 1'b0;
    end
  end

  // Shift stage: MISO always shows the MSB of a left-shifting copy, so it reads 0 past the frame
  always_ff @(posedge system_clock) begin
    if (reset) begin
      r_bit_cnt <= '0;
      spi_miso  <= 1'b0;
    end else if (w_load) begin
      r_bit_cnt <= '0;
      spi_miso  <= 1'b0;
    end else if (r_state == S_SHIFT) begin
      if (w_sclk_rise) spi_miso <= r_tx_shift[FRAME_BITS-1];
      r_bit_cnt <= w_bit_cnt_nxt;
    end
  end

  always_ff @(posedge system_clock) begin
    if (w_load) begin
      r_tx_shift <= r_pending;
    end else if (r_state == S_SHIFT && w_sclk_fall) begin
      r_tx_shift <= r_tx_shift << 1;
      if (r_bit_cnt < CMD_BITS) r_rx_cmd <= {r_rx_cmd[14:0], w_mosi};
    end
  end

  assign w_addr = r_rx_cmd[12:8];

  always_comb begin
    w_null32 = awake ? {16'h2200, r_sample_cnt} : {READY_WORD, 16'h0};
    w_op     = OP_NULL;
    w_resp32 = w_null32;
    if (r_rx_cmd == 16'h0655) begin
      w_op     = OP_UNLOCK;
      w_resp32 = {r_rx_cmd, 16'h0};
    end else if (r_rx_cmd == 16'h0555) begin
      w_op     = OP_LOCK;
      w_resp32 = {r_rx_cmd, 16'h0};
    end else if (r_rx_cmd == 16'h0033) begin
      w_op     = OP_WAKE;
      w_resp32 = {r_rx_cmd, 16'h0};
    end else if (r_rx_cmd == 16'h0022) begin
      w_op     = OP_STBY;
      w_resp32 = {r_rx_cmd, 16'h0};
    end else if (r_rx_cmd == 16'h0011) begin
      w_op     = OP_RST;
      w_resp32 = {READY_WORD, 16'h0};
    end else if (r_rx_cmd[15:13] == 3'b010) begin
      if (unlocked) begin
        w_op     = OP_WREG;
        w_resp32 = {3'b001, r_rx_cmd[12:0], 16'h0};
      end
    end else if (r_rx_cmd[15:13] == 3'b001) begin
      w_op     = OP_RREG;
      w_resp32 = {3'b001, w_addr, r_regfile[w_addr], 16'h0};
    end
  end

  assign w_resp_frame = FRAME_BITS'(w_resp32) << (FRAME_BITS - 32);

  // Decode stage: commit the command and stage the response for the next frame
  always_ff @(posedge system_clock) begin
    if (reset) begin
      r_pending    <= READY_FRAME;
      frame_count  <= '0;
      last_command <= '0;
      unlocked     <= 1'b0;
      awake        <= 1'b0;
      for (int i = 0; i < 32; i++) r_regfile[i] <= '0;
    end else if (w_decode) begin
      r_pending    <= w_resp_frame;
      last_command <= r_rx_cmd;
      frame_count  <= frame_count + 1'b1;
      case (w_op)
        OP_UNLOCK: unlocked <= 1'b1;
        OP_LOCK:   unlocked <= 1'b0;
        OP_WAKE:   awake    <= 1'b1;
        OP_STBY:   awake    <= 1'b0;
        OP_RST: begin
          unlocked <= 1'b0;
          awake    <= 1'b0;
          for (int i = 0; i < 32; i++) r_regfile[i] <= '0;
        end
        OP_WREG:   r_regfile[w_addr] <= r_rx_cmd[7:0];
        default:   ;
      endcase
    end
  end

  // A terminal count while DRDY is still low yields a one-cycle high pulse before it drops again
  always_ff @(posedge system_clock) begin
    if (reset) begin
      r_drdy_cnt     <= '0;
      spi_drdy       <= 1'b1;
      r_sample_cnt   <= '0;
      r_drdy_repulse <= 1'b0;
    end else if (w_decode && w_op == OP_RST) begin
      r_drdy_cnt     <= '0;
      spi_drdy       <= 1'b1;
      r_sample_cnt   <= '0;
      r_drdy_repulse <= 1'b0;
    end else if (w_decode && w_op == OP_WAKE) begin
      r_drdy_cnt     <= '0;
      r_drdy_repulse <= 1'b0;
    end else if (!awake || (w_decode && w_op == OP_STBY)) begin
      r_drdy_cnt     <= '0;
      spi_drdy       <= 1'b1;
      r_drdy_repulse <= 1'b0;
    end else if (r_drdy_cnt == DRDY_LAST) begin
      r_drdy_cnt     <= '0;
      r_sample_cnt   <= r_sample_cnt + 1'b1;
      spi_drdy       <= ~spi_drdy;
      r_drdy_repulse <= ~spi_drdy;
    end else begin
      r_drdy_cnt <= r_drdy_cnt + 1'b1;
      if (r_drdy_repulse) begin
        spi_drdy       <= 1'b0;
        r_drdy_repulse <= 1'b0;
      end else if (w_cs_fall) begin
        spi_drdy <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ads131_spi_responder.sv
// Directed bench for ads131_spi_responder: a command-level model predicts every returned
// frame and the status outputs, backed by hand-computed literal expectations.
module tb_ads131_spi_responder;
  localparam int DP = 64;

  logic        clk = 1'b0;
  logic        rst, sclk, cs, mosi;
  logic        miso, drdy, unl, awk;
  logic [7:0]  fc;
  logic [15:0] lc;

  int cyc       = 0;
  int nvec      = 0;
  int nerr      = 0;
  int last_rise = 0;
  bit chk_en    = 1'b0;

  // command-level model state
  logic        m_unl, m_awk;
  logic [7:0]  m_regs [32];
  logic [31:0] m_pend;
  logic [7:0]  m_fc;
  logic [15:0] m_lc;
  int          m_wake_edge, m_samp_base;

  ads131_spi_responder #(
    .FRAME_BITS(32), .READY_WORD(16'hFF04), .DRDY_PERIOD(DP), .SYNC_STAGES(2)
  ) dut (
    .system_clock(clk), .reset(rst), .spi_sclk(sclk), .spi_cs(cs), .spi_mosi(mosi),
    .spi_miso(miso), .spi_drdy(drdy), .frame_count(fc), .last_command(lc),
    .unlocked(unl), .awake(awk)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic m_reset();
    m_unl = 1'b0; m_awk = 1'b0; m_fc = '0; m_lc = '0;
    m_pend = 32'hFF04_0000; m_wake_edge = 0; m_samp_base = 0;
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
  endtask

  // samples counted = terminal counts strictly before clock edge e
  function automatic int m_samples(input int e);
    return m_samp_base + (m_awk ? (e - m_wake_edge - 1) / DP : 0);
  endfunction

  task automatic m_apply(input logic [15:0] c, input int e);
    logic [31:0] nul;
    nul  = m_awk ? {16'h2200, 16'(m_samples(e))} : 32'hFF04_0000;
    m_fc = m_fc + 8'd1;
    m_lc = c;
    if (c == 16'h0655) begin
      m_unl = 1'b1; m_pend = {c, 16'h0};
    end else if (c == 16'h0555) begin
      m_unl = 1'b0; m_pend = {c, 16'h0};
    end else if (c == 16'h0033) begin
      m_samp_base = m_samples(e); m_awk = 1'b1; m_wake_edge = e; m_pend = {c, 16'h0};
    end else if (c == 16'h0022) begin
      m_samp_base = m_samples(e); m_awk = 1'b0; m_pend = {c, 16'h0};
    end else if (c == 16'h0011) begin
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_unl = 1'b0; m_awk = 1'b0; m_samp_base = 0; m_pend = 32'hFF04_0000;
    end else if (c[15:13] == 3'b010) begin
      if (m_unl) begin
        m_regs[c[12:8]] = c[7:0];
        m_pend = {3'b001, c[12:0], 16'h0};
      end else begin
        m_pend = nul;
      end
    end else if (c[15:13] == 3'b001) begin
      m_pend = {3'b001, c[12:8], m_regs[c[12:8]], 16'h0};
    end else begin
      m_pend = nul;
    end
  endtask

  // per-cycle comparison while a frame is on the wire (status is stable then)
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("frame_count", 32'(fc), 32'(m_fc));
      chk("last_command", 32'(lc), 32'(m_lc));
      chk("unlocked", 32'(unl), 32'(m_unl));
      chk("awake", 32'(awk), 32'(m_awk));
      if (!m_awk) chk("drdy_idle", 32'(drdy), 32'd1);
    end
  end

  task automatic frame(input logic [31:0] tx, input int nbits, input int rst_at,
                       input bit drdy_chk, output logic [31:0] rx, output int rise_cyc);
    rx = '0;
    cs = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    if (drdy_chk) chk("drdy_cs_release", 32'(drdy), 32'd1);
    @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        chk_en = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_reset();
      end
      sclk = 1'b1;
      mosi = tx[31-i];
      repeat (4) @(negedge clk);
      rx = {rx[30:0], miso};
      sclk = 1'b0;
      repeat (4) @(negedge clk);
    end
    chk_en = 1'b0;
    cs = 1'b1;
    rise_cyc = cyc;
    repeat (10) @(negedge clk);
  endtask

  // full frame; decode lands 4 clock edges after cs rise (2 sync + edge detect + decode)
  task automatic xfer(input logic [31:0] w, input bit drdy_chk, output logic [31:0] rx);
    logic [31:0] exp;
    int rc;
    exp = m_pend;
    frame(w, 32, -1, drdy_chk, rx, rc);
    chk("miso_word", rx, exp);
    m_apply(w[31:16], rc + 4);
    last_rise = rc;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] rx;
    int rc;
    rst = 1'b1; cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
    m_reset();
    repeat (4) @(negedge clk);
    chk("rst_miso", 32'(miso), 32'd0);
    chk("rst_drdy", 32'(drdy), 32'd1);
    chk("rst_fc", 32'(fc), 32'd0);
    chk("rst_lc", 32'(lc), 32'd0);
    chk("rst_unl", 32'(unl), 32'd0);
    chk("rst_awk", 32'(awk), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // NULL after reset returns the ready word
    xfer(32'h0000_0000, 1'b0, rx);
    chk("t1_miso", rx, 32'hFF04_0000);
    chk("t1_fc", 32'(fc), 32'd1);
    chk("t1_drdy", 32'(drdy), 32'd1);
    chk("t1_unl", 32'(unl), 32'd0);

    // UNLOCK echoed on the following frame
    xfer(32'h0655_0000, 1'b0, rx);
    chk("t2_lc_unlock", 32'(lc), 32'h0655);
    xfer(32'h0000_0000, 1'b0, rx);
    chk("t2_miso", rx, 32'h0655_0000);
    chk("t2_unl", 32'(unl), 32'd1);
    chk("t2_lc", 32'(lc), 32'h0000);

    // register write then read-back
    xfer(32'h4B68_0000, 1'b0, rx);
    xfer(32'h2B00_0000, 1'b0, rx);
    chk("t3_wreg_resp", rx, 32'h2B68_0000);
    xfer(32'h0000_0000, 1'b0, rx);
    chk("t3_rreg_resp", rx, 32'h2B68_0000);

    // locked write is ignored
    xfer(32'h0555_0000, 1'b0, rx);
    chk("t4_unl", 32'(unl), 32'd0);
    xfer(32'h4F0F_0000, 1'b0, rx);
    xfer(32'h2F00_0000, 1'b0, rx);
    chk("t4_locked_wreg", rx, 32'hFF04_0000);
    xfer(32'h0000_0000, 1'b0, rx);
    chk("t4_rreg_resp", rx, 32'h2F00_0000);

    // unknown opcode behaves as NULL
    xfer(32'h1234_0000, 1'b0, rx);
    chk("unk_lc", 32'(lc), 32'h1234);
    xfer(32'h0000_0000, 1'b0, rx);

    // short frame is discarded, pending response kept
    xfer(32'h2B00_0000, 1'b0, rx);
    frame(32'h0655_0000, 20, -1, 1'b0, rx, rc);
    chk("t6_fc_held", 32'(fc), 32'd13);
    chk("t6_unl_held", 32'(unl), 32'd0);
    xfer(32'h0000_0000, 1'b0, rx);
    chk("t6_pending_kept", rx, 32'h2B68_0000);

    // WAKEUP: DRDY falls DP edges after decode, releases on cs fall
    xfer(32'h0033_0000, 1'b0, rx);
    while (cyc < last_rise + 4 + DP - 1) @(negedge clk);
    chk("t5_drdy_pre_tc", 32'(drdy), 32'd1);
    @(negedge clk);
    chk("t5_drdy_fall", 32'(drdy), 32'd0);
    xfer(32'h0000_0000, 1'b1, rx);
    chk("t5_wake_echo", rx, 32'h0033_0000);
    xfer(32'h0000_0000, 1'b0, rx);
    chk("t5_null_status", 32'(rx[31:16]), 32'h2200);
    xfer(32'h0022_0000, 1'b0, rx);
    xfer(32'h0000_0000, 1'b0, rx);
    chk("stby_echo", rx, 32'h0022_0000);
    chk("stby_drdy", 32'(drdy), 32'd1);

    // RESET command clears registers and lock
    xfer(32'h0655_0000, 1'b0, rx);
    xfer(32'h4B55_0000, 1'b0, rx);
    xfer(32'h0011_0000, 1'b0, rx);
    chk("rstcmd_wreg_resp", rx, 32'h2B55_0000);
    chk("rstcmd_unl", 32'(unl), 32'd0);
    xfer(32'h2B00_0000, 1'b0, rx);
    chk("rstcmd_resp", rx, 32'hFF04_0000);
    xfer(32'h0000_0000, 1'b0, rx);
    chk("rstcmd_reg_clear", rx, 32'h2B00_0000);

    // reset asserted mid-frame restores reset values
    xfer(32'h0655_0000, 1'b0, rx);
    frame(32'h0655_0000, 32, 10, 1'b0, rx, rc);
    chk("midrst_fc", 32'(fc), 32'd0);
    chk("midrst_lc", 32'(lc), 32'd0);
    chk("midrst_unl", 32'(unl), 32'd0);
    chk("midrst_awk", 32'(awk), 32'd0);
    chk("midrst_drdy", 32'(drdy), 32'd1);
    xfer(32'h0000_0000, 1'b0, rx);
    chk("midrst_null", rx, 32'hFF04_0000);
    chk("midrst_fc1", 32'(fc), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
